// File: rtl/fifo_arb_pkg.sv
// Shared types and elaboration-time helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // A single requester still needs a one-bit index field.
    function automatic int id_width(input int num_req);
        return (num_req < 2) ? 1 : clog2(num_req);
    endfunction

    localparam int DEFAULT_NUM_REQ  = 4;
    localparam int DEFAULT_ID_WIDTH = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after `last`, wrapping,
// so the previous winner is considered last.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int ID_WIDTH = DEFAULT_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                found,
    output logic [ID_WIDTH-1:0] pick
);

    logic [ID_WIDTH-1:0] idx_s;
    logic                hit_s;

    // Priority scan starting one past the previous owner.
    always_comb begin
        found = 1'b0;
        pick  = {ID_WIDTH{1'b0}};
        idx_s = {ID_WIDTH{1'b0}};
        hit_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_WIDTH'((int'(last) + k) % NUM_REQ);
            hit_s = ~found & req[idx_s];
            pick  = hit_s ? idx_s : pick;
            found = found | hit_s;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among producers.
// Define FIFO_ARB_SOURCE_TAG_EN to prepend the owner index to every FIFO word.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_WIDTH  = id_width(NUM_REQ),
`ifdef FIFO_ARB_SOURCE_TAG_EN
    localparam int FIFO_WIDTH = DATA_WIDTH + ID_WIDTH
`else
    localparam int FIFO_WIDTH = DATA_WIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_we,
    output logic [FIFO_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam int BEAT_WIDTH = clog2(MAX_BURST) + 1;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]   LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    arb_state_t          state_r;
    logic [ID_WIDTH-1:0] owner_r;
    logic [ID_WIDTH-1:0] last_r;
    logic [BEAT_WIDTH-1:0] beats_r;

    logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];
    logic                  owner_valid_s;
    logic                  xfer_s;
    logic                  release_s;
    logic [ID_WIDTH-1:0]   pick_last_s;
    logic                  found_s;
    logic [ID_WIDTH-1:0]   pick_s;

    // Unpack the flat payload bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Handshake decode; while granted the owner itself is the rotation origin.
    always_comb begin
        owner_valid_s = req_valid[owner_r];
        xfer_s        = 1'b0;
        release_s     = 1'b0;
        pick_last_s   = last_r;
        if (state_r == GRANT) begin
            xfer_s      = owner_valid_s & ~fifo_full;
            release_s   = (xfer_s & (beats_r == LAST_BEAT)) | ~owner_valid_s;
            pick_last_s = owner_r;
        end else begin
            pick_last_s = last_r;
        end
    end

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (pick_last_s),
        .found (found_s),
        .pick  (pick_s)
    );

    // Write-port drive; fifo_we stays up under full so the FIFO's own gating drops it.
    always_comb begin
        fifo_we     = 1'b0;
        fifo_data   = {FIFO_WIDTH{1'b0}};
        req_ready   = {NUM_REQ{1'b0}};
        grant_valid = 1'b0;
        grant_id    = {ID_WIDTH{1'b0}};
        if (state_r == GRANT) begin
            fifo_we            = owner_valid_s;
`ifdef FIFO_ARB_SOURCE_TAG_EN
            fifo_data          = {owner_r, data_arr_s[owner_r]};
`else
            fifo_data          = data_arr_s[owner_r];
`endif
            req_ready[owner_r] = xfer_s;
            grant_valid        = 1'b1;
            grant_id           = owner_r;
        end else begin
            grant_valid = 1'b0;
        end
    end

    // Grant state machine: acquire, count beats, release with same-cycle re-arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= {ID_WIDTH{1'b0}};
            last_r  <= LAST_INIT;
            beats_r <= {BEAT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= GRANT;
                        owner_r <= pick_s;
                        last_r  <= pick_s;
                        beats_r <= {BEAT_WIDTH{1'b0}};
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        if (found_s) begin
                            owner_r <= pick_s;
                            last_r  <= pick_s;
                            beats_r <= {BEAT_WIDTH{1'b0}};
                        end else begin
                            state_r <= IDLE;
                            last_r  <= owner_r;
                            beats_r <= {BEAT_WIDTH{1'b0}};
                        end
                    end else if (xfer_s) begin
                        beats_r <= beats_r + {{(BEAT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    beats_r <= {BEAT_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter with the default 4x8, burst-4 configuration.
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_SOURCE_TAG_EN
    localparam int FW = 10;
    localparam logic [FW-1:0] TAG_EXP = 10'b11_1010_0101;
`else
    localparam int FW = 8;
    localparam logic [FW-1:0] TAG_EXP = 8'hA5;
`endif

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [31:0]   req_data;
    logic [3:0]    req_ready;
    logic          fifo_we;
    logic [FW-1:0] fifo_data;
    logic          fifo_full;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic [7:0]    obs;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_write_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_we     (fifo_we),
        .fifo_data   (fifo_data),
        .fifo_full   (fifo_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign obs = {grant_valid, grant_id, fifo_we, req_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [FW-1:0] exp_data(input logic [1:0] id, input logic [7:0] d);
`ifdef FIFO_ARB_SOURCE_TAG_EN
        return {id, d};
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        fifo_full = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        fifo_full = 1'b0;
        #2;
        n_checks++;
        if (obs !== 8'b0_00_0_0000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want %b", obs, 8'b0_00_0_0000);
        end
        n_checks++;
        if (fifo_data !== {FW{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", fifo_data);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs !== 8'b0_00_0_0000) begin
            n_fail++;
            $display("FAIL idle_no_req got %b want %b", obs, 8'b0_00_0_0000);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid        = 4'b0100;
        req_data[23:16]  = 8'h10;
        #1;
        n_checks++;
        if (obs !== 8'b0_00_0_0000) begin
            n_fail++;
            $display("FAIL single_latency got %b want %b", obs, 8'b0_00_0_0000);
        end
        step();
        // Six words, burst of four then an immediate re-grant: no idle cycle in between.
        for (int w = 0; w < 6; w++) begin
            req_data[23:16] = 8'(8'h10 + w);
            #1;
            n_checks++;
            if (obs !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
                n_fail++;
                $display("FAIL single_word%0d got %b want %b", w, obs, {1'b1, 2'd2, 1'b1, 4'b0100});
            end
            n_checks++;
            if (fifo_data !== exp_data(2'd2, 8'(8'h10 + w))) begin
                n_fail++;
                $display("FAIL single_data%0d got %h want %h", w, fifo_data, exp_data(2'd2, 8'(8'h10 + w)));
            end
            step();
        end
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd2, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL single_drop got %b want %b", obs, {1'b1, 2'd2, 1'b0, 4'b0000});
        end
        step();
        n_checks++;
        if (obs !== 8'b0_00_0_0000) begin
            n_fail++;
            $display("FAIL single_idle got %b want %b", obs, 8'b0_00_0_0000);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] id;
        apply_reset();
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_valid = 4'b1111;
        step();
        for (int t = 0; t < 5; t++) begin
            id = 2'(t % 4);
            for (int b = 0; b < 4; b++) begin
                #1;
                n_checks++;
                if (obs !== {1'b1, id, 1'b1, 4'b0001 << id}) begin
                    n_fail++;
                    $display("FAIL rr_t%0d_b%0d got %b want %b", t, b, obs, {1'b1, id, 1'b1, 4'b0001 << id});
                end
                n_checks++;
                if (fifo_data !== exp_data(id, 8'(8'hA0 + 8'h11 * id))) begin
                    n_fail++;
                    $display("FAIL rr_data_t%0d got %h want %h", t, fifo_data, exp_data(id, 8'(8'hA0 + 8'h11 * id)));
                end
                step();
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_full_stall();
        apply_reset();
        req_data[23:16] = 8'h77;
        req_data[15:8]  = 8'h40;
        req_valid       = 4'b0110;
        step();
        for (int b = 0; b < 2; b++) begin
            req_data[15:8] = 8'(8'h40 + b);
            #1;
            n_checks++;
            if (obs !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
                n_fail++;
                $display("FAIL full_pre%0d got %b want %b", b, obs, {1'b1, 2'd1, 1'b1, 4'b0010});
            end
            step();
        end
        req_data[15:8] = 8'h42;
        fifo_full      = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_checks++;
            if (obs !== {1'b1, 2'd1, 1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL full_stall%0d got %b want %b", s, obs, {1'b1, 2'd1, 1'b1, 4'b0000});
            end
            step();
        end
        fifo_full = 1'b0;
        for (int b = 2; b < 4; b++) begin
            req_data[15:8] = 8'(8'h40 + b);
            #1;
            n_checks++;
            if (obs !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
                n_fail++;
                $display("FAIL full_post%0d got %b want %b", b, obs, {1'b1, 2'd1, 1'b1, 4'b0010});
            end
            n_checks++;
            if (fifo_data !== exp_data(2'd1, 8'(8'h40 + b))) begin
                n_fail++;
                $display("FAIL full_data%0d got %h want %h", b, fifo_data, exp_data(2'd1, 8'(8'h40 + b)));
            end
            step();
        end
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL full_release got %b want %b", obs, {1'b1, 2'd2, 1'b1, 4'b0100});
        end
        req_valid = 4'b0000;
        step();
        step();
    endtask

    task automatic test_drop();
        apply_reset();
        req_data[31:24] = 8'h3C;
        req_valid       = 4'b1000;
        step();
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd3, 1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL drop_first got %b want %b", obs, {1'b1, 2'd3, 1'b1, 4'b1000});
        end
        step();
        req_valid      = 4'b0001;
        req_data[7:0]  = 8'h0A;
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd3, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL drop_nowrite got %b want %b", obs, {1'b1, 2'd3, 1'b0, 4'b0000});
        end
        step();
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd0, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL drop_handover got %b want %b", obs, {1'b1, 2'd0, 1'b1, 4'b0001});
        end
        n_checks++;
        if (fifo_data !== exp_data(2'd0, 8'h0A)) begin
            n_fail++;
            $display("FAIL drop_data got %h want %h", fifo_data, exp_data(2'd0, 8'h0A));
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 4'b0100;
        step();
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL rstmid_grant got %b want %b", obs, {1'b1, 2'd2, 1'b1, 4'b0100});
        end
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'b0_00_0_0000) begin
            n_fail++;
            $display("FAIL rstmid_async got %b want %b", obs, 8'b0_00_0_0000);
        end
        req_valid = 4'b1111;
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== 8'b0_00_0_0000) begin
            n_fail++;
            $display("FAIL rstmid_idle got %b want %b", obs, 8'b0_00_0_0000);
        end
        step();
        #1;
        n_checks++;
        if (obs !== {1'b1, 2'd0, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL rstmid_first got %b want %b", obs, {1'b1, 2'd0, 1'b1, 4'b0001});
        end
        req_valid = 4'b0000;
        step();
        step();
    endtask

    task automatic test_tag();
        apply_reset();
        req_data[31:24] = 8'hA5;
        req_valid       = 4'b1000;
        step();
        #1;
        n_checks++;
        if (fifo_data !== TAG_EXP) begin
            n_fail++;
            $display("FAIL tag_data got %h want %h", fifo_data, TAG_EXP);
        end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_tag();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (write enable, data in, full flag) among NUM_REQ producers.
- Uses round-robin arbitration with bounded bursts: a granted producer holds the port for up to MAX_BURST accepted words, or until it drops valid.
- Sits between producer blocks and the FIFO's write side and drives the FIFO's write enable and data in directly.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, payload width per requester.
- MAX_BURST, 4, maximum accepted words per grant (≥1).
- ID_WIDTH, clog2(NUM_REQ), localparam; requester index width.
- FIFO_WIDTH, DATA_WIDTH (or DATA_WIDTH+ID_WIDTH, see Optional Feature), localparam.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; word of requester i accepted this cycle.
- fifo_we  out  1  to FIFO write enable.
- fifo_data  out  FIFO_WIDTH  to FIFO data in.
- fifo_full  in  1  from FIFO full flag; combinational within the cycle.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  ID_WIDTH  current owner index; 0 when not granted.

Behaviour:
- State machine has two states. In IDLE, no owner is held. In GRANT, the port is owned by `owner`.
- Registers are `state`, `owner`, `last` (most recent owner) and `beats` (width clog2(MAX_BURST)+1).
- Reset values (async, immediate):
  - state=IDLE, owner=0, last=NUM_REQ-1, beats=0.
  - All outputs 0, so requester 0 has first priority.
- Round-robin pick: scan req_valid starting at last+1 (mod NUM_REQ) and take the first set bit. The previous owner is scanned last and may win again if it is the only requester.
- In IDLE:
  - If any req_valid is set, register owner=pick, last=pick, beats=0 and move to GRANT.
  - The first write happens the cycle after valid is seen (1-cycle arbitration latency).
- In GRANT, outputs are combinational:
  - fifo_we = req_valid[owner].
  - fifo_data = req_data[owner].
  - req_ready[owner] = req_valid[owner] & ~fifo_full.
  - grant_valid=1, grant_id=owner.
- Transfer: a transfer occurs when req_valid[owner] & ~fifo_full. On each transfer, beats increments.
- Release: the grant is released at the edge when:
  - (a) a transfer occurs with beats==MAX_BURST-1, or
  - (b) req_valid[owner]==0.
- On release, re-arbitrate in the same cycle over the current req_valid, using owner as `last`:
  - If the pick exists, load the new owner (or the same one), reset beats=0 and stay in GRANT. There is no bubble cycle.
  - Otherwise go to IDLE.
- fifo_full held high:
  - The owner keeps the grant, fifo_we stays asserted, and no transfer occurs.
  - beats does not advance, so the FIFO's own ~full gating drops the writes.
- Requester contract: valid/data must remain stable until ready. A requester deasserting valid without a transfer forfeits the grant (case b).
- Simultaneous events: in a cycle with a final-beat transfer and a new valid from another requester, the other requester wins the next cycle if it is next in round-robin order.
- Reset mid-burst:
  - fifo_we and req_ready drop asynchronously, and the word in that cycle is not written.
  - After release, arbitration restarts from requester 0.
- MAX_BURST=1 degenerates to per-word round-robin.

Optional Feature:
- Macro: FIFO_ARB_SOURCE_TAG_EN.
- Defined:
  - FIFO_WIDTH=DATA_WIDTH+ID_WIDTH.
  - fifo_data = {owner, req_data[owner]}, so the source ID is in the MSBs.
  - Each FIFO entry identifies its producer.
- Undefined:
  - FIFO_WIDTH=DATA_WIDTH, fifo_data = payload only.
  - No other behaviour changes.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state typedef (IDLE, GRANT);
  - the clog2 constant function;
  - a localparam for the ID width helper.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: request vector, last index.
  - Outputs: found flag, pick index.
  - Instantiated once and shared by the IDLE and release paths.

Test Plan:
- Single requester: req_valid=4'b0100 with 6 words, fifo_full=0.
  - Grant 2 one cycle later; 4 words written back-to-back.
  - Release, immediate re-grant to 2 with no bubble; remaining 2 words written.
- All four valid continuously, MAX_BURST=4: grant order 0,1,2,3,0.
  - Each tenure is exactly 4 fifo_we cycles; req_ready is one-hot and matches grant_id.
- fifo_full asserted for 3 cycles mid-burst of requester 1 after 2 beats.
  - req_ready low during those cycles, beats frozen, grant held.
  - 2 more beats written after full clears, then release.
- Requester 3 drops valid after 1 beat while 0 is waiting: grant moves to 0 next cycle with no write from 3.
- Assert rst_n=0 during a burst of requester 2.
  - fifo_we and grant_valid go 0 in the same cycle.
  - After release with 4'b1111 valid, the first grant is 0.
- With FIFO_ARB_SOURCE_TAG_EN, requester 3 writes 8'hA5: fifo_data = 10'b11_1010_0101.
  - Without the macro: 8'hA5.
